dff_bank_arbiter: RTL

Round-robin arbiter and write sequencer for one shared WIDTH-bit register built from D flip-flops. Up to N_REQ requesters compete to load a word into the register. The block grants one requester at a time, drives the register's D inputs and load enable, and returns a one-cycle acknowledge. It sits between requester logic and the shared register bank and owns that bank's write timing.

---
 rtl/dff_bank_arbiter_if.sv | 19 +
 rtl/dff_bank_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/dff_bank_arbiter_if.sv
// Requester-side bus of the shared-register arbiter. The master modport is the requester
// group, and the slave modport is the arbiter itself.
`timescale 1ns/1ps
interface dff_bank_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] wdata;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       ack;
    logic [WIDTH-1:0]       q;
    logic [IDW-1:0]         owner;
    logic                   busy;

    modport master (output req, wdata, input gnt, ack, q, owner, busy);
    modport slave  (input req, wdata, output gnt, ack, q, owner, busy);
endinterface

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter and write sequencer for one shared WIDTH-bit register.
// Each write walks through IDLE -> GRANT -> WRITE -> ACK. The register loads on the edge that enters WRITE.
`timescale 1ns/1ps
module dff_bank_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
) (
    input  logic               clk,
    input  logic               reset,
    dff_bank_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WRITE = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t             state_r, next_state_s;
    logic [IDW-1:0]     sel_r, sel_nxt_s;
    logic [IDW-1:0]     ptr_r, ptr_nxt_s;
    logic [N_REQ-1:0]   gnt_r, gnt_nxt_s;
    logic [N_REQ-1:0]   ack_r, ack_nxt_s;
    logic [WIDTH-1:0]   q_r, q_nxt_s;
    logic [IDW-1:0]     owner_r, owner_nxt_s;
    logic               busy_r;
    logic               found_s;
    logic [IDW-1:0]     win_s;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDW-1:0] idx);
        logic [N_REQ-1:0] v;
        v = {N_REQ{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Pick the first active requester after ptr_r, wrapping modulo N_REQ
    always_comb begin
        found_s = 1'b0;
        win_s   = {IDW{1'b0}};
        for (int i = 1; i <= N_REQ; i++) begin
            int idx;
            idx = (int'(ptr_r) + i) % N_REQ;
            if (!found_s && bus.req[idx]) begin
                found_s = 1'b1;
                win_s   = IDW'(idx);
            end else begin
                win_s   = win_s;
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        next_state_s = state_r;
        sel_nxt_s    = sel_r;
        ptr_nxt_s    = ptr_r;
        gnt_nxt_s    = gnt_r;
        ack_nxt_s    = {N_REQ{1'b0}};
        q_nxt_s      = q_r;
        owner_nxt_s  = owner_r;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    sel_nxt_s    = win_s;
                    gnt_nxt_s    = onehot(win_s);
                    next_state_s = GRANT;
                end else begin
                    gnt_nxt_s    = {N_REQ{1'b0}};
                end
            end
            GRANT: begin
                // wdata is sampled only on this edge; later changes cannot affect the write
                if (bus.req[sel_r]) begin
                    q_nxt_s      = bus.wdata[sel_r*WIDTH +: WIDTH];
                    owner_nxt_s  = sel_r;
                    next_state_s = WRITE;
                end else begin
                    gnt_nxt_s    = {N_REQ{1'b0}};
                    next_state_s = IDLE;
                end
            end
            WRITE: begin
                gnt_nxt_s    = {N_REQ{1'b0}};
                ack_nxt_s    = onehot(sel_r);
                ptr_nxt_s    = sel_r;
                next_state_s = ACK;
            end
            ACK: begin
                gnt_nxt_s    = {N_REQ{1'b0}};
                next_state_s = IDLE;
            end
            default: begin
                gnt_nxt_s    = {N_REQ{1'b0}};
                next_state_s = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            sel_r   <= {IDW{1'b0}};
            ptr_r   <= IDW'(N_REQ - 1);
            gnt_r   <= {N_REQ{1'b0}};
            ack_r   <= {N_REQ{1'b0}};
            q_r     <= {WIDTH{1'b0}};
            owner_r <= {IDW{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            sel_r   <= sel_nxt_s;
            ptr_r   <= ptr_nxt_s;
            gnt_r   <= gnt_nxt_s;
            ack_r   <= ack_nxt_s;
            q_r     <= q_nxt_s;
            owner_r <= owner_nxt_s;
            busy_r  <= (next_state_s != IDLE);
        end
    end

    assign bus.gnt   = gnt_r;
    assign bus.ack   = ack_r;
    assign bus.q     = q_r;
    assign bus.owner = owner_r;
    assign bus.busy  = busy_r;

endmodule
